fetch_unit: RTL and testbench

Instruction fetch stage for the pipelined core. Keeps a fetch PC, issues requests to instruction memory over a req/ready/rvalid handshake, and buffers returned {pc, instr} pairs in a small prefetch FIFO. The decode stage drains the FIFO over a valid/ready interface. A redirect port from execute (branch/jump) flushes the stage and restarts fetch at a new PC.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with prefetch FIFO; optional perf counters via FETCH_PERF_EN
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_fetch_pc, r_req_pc;
    logic [31:0] r_pc_mem [FIFO_DEPTH];
    logic [31:0] r_instr_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count, w_used;
    logic w_outstanding, w_credit, w_accept, w_push, w_pop;
    assign imem_addr = r_fetch_pc;
    assign out_valid = (r_count != '0) && !reset;
    assign out_pc    = r_pc_mem[r_rptr];
    assign out_instr = r_instr_mem[r_rptr];
    // state register
    always_ff @(posedge clk) begin
        r_state <= reset ? S_FETCH : w_next;
    end
    // credit check, request handshake and next-state selection
    always_comb begin
        w_outstanding = r_state != S_FETCH;
        w_used        = r_count + {{AW{1'b0}}, w_outstanding};
        w_credit      = w_used < (AW+1)'(FIFO_DEPTH);
        imem_req      = !reset && !redirect_valid && w_credit &&
                        (r_state == S_FETCH || (r_state == S_WAIT && imem_rvalid));
        w_accept      = imem_req && imem_ready;
        w_push        = r_state == S_WAIT && imem_rvalid && !redirect_valid;
        w_pop         = out_valid && out_ready && !redirect_valid;
        w_next        = redirect_valid ? (w_outstanding ? S_DISCARD : S_FETCH) :
                        w_accept ? S_WAIT :
                        (imem_rvalid && w_outstanding) ? S_FETCH : r_state;
    end
    // fetch pc advances on accept, jumps word-aligned on redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_req_pc   <= r_fetch_pc;
        end
    end
    // fifo pointers and occupancy, flushed by redirect
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // fifo storage of {pc, instr} pairs
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]    <= r_req_pc;
            r_instr_mem[r_wptr] <= imem_rdata;
        end
    end
`ifdef FETCH_PERF_EN
    logic w_drop;
    assign w_drop = r_state == S_DISCARD && imem_rvalid;
    // delivered and flushed instruction counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(w_pop);
            perf_flushed <= perf_flushed + (redirect_valid ? 32'(r_count) : 32'd0) + 32'(w_drop);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based model
module tb_fetch_unit;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b1, imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, out_instr, out_pc;
    logic        redirect_valid = 1'b0, out_valid, out_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif
    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
    );
    int checks = 0, failures = 0;
    logic [31:0] m_pc, m_req_pc, m_fetched, m_flushed;
    logic        m_infl, m_drop;
    logic [63:0] m_q[$];
    logic [31:0] popped[$];
    logic        mp = 1'b0;
    int          mc = 0, lat = 1;
    logic [31:0] ma = '0, force_data = '0;
    logic        rand_lat = 1'b0, force_rv = 1'b0;
    logic        t_reset = 1'b1, t_redir = 1'b0, t_ready = 1'b0, t_oready = 1'b0;
    logic [31:0] t_rpc = '0;
    logic        s_req, s_ov, s_rv;
    logic [31:0] s_addr, s_pc, s_pf, s_pfl;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        logic e_req, e_ov, acc, pop;
        @(negedge clk);
        reset = t_reset; redirect_valid = t_redir; redirect_pc = t_rpc;
        imem_ready = t_ready; out_ready = t_oready;
        imem_rvalid = force_rv || (mp && mc == 0);
        imem_rdata = force_rv ? force_data : (ma ^ 32'hA5A5_0000);
        #1;
        e_req = !reset && !redirect_valid && (m_q.size() + int'(m_infl) < DEPTH) &&
                (!m_infl || (!m_drop && imem_rvalid));
        e_ov = !reset && m_q.size() != 0;
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) begin
            chk("out_pc", out_pc, m_q[0][63:32]);
            chk("out_instr", out_instr, m_q[0][31:0]);
        end
        s_req = imem_req; s_addr = imem_addr; s_ov = out_valid; s_pc = out_pc; s_rv = imem_rvalid;
`ifdef FETCH_PERF_EN
        if (!reset) begin
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_flushed", perf_flushed, m_flushed);
        end
        s_pf = perf_fetched; s_pfl = perf_flushed;
`else
        s_pf = '0; s_pfl = '0;
`endif
        acc = e_req && imem_ready;
        pop = e_ov && out_ready && !redirect_valid;
        if (reset) begin
            m_pc = 32'h0; m_q.delete(); m_infl = 1'b0; m_drop = 1'b0;
            m_fetched = '0; m_flushed = '0;
        end else begin
            if (m_drop && imem_rvalid) m_flushed++;
            if (redirect_valid) begin
                m_flushed += m_q.size();
                m_q.delete();
                m_drop = m_infl;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (pop) begin
                    popped.push_back(m_q[0][63:32]);
                    void'(m_q.pop_front());
                    m_fetched++;
                end
                if (m_infl && imem_rvalid) begin
                    if (!m_drop) m_q.push_back({m_req_pc, imem_rdata});
                    m_infl = 1'b0; m_drop = 1'b0;
                end
                if (acc) begin
                    m_req_pc = m_pc; m_pc += 32'd4; m_infl = 1'b1;
                end
            end
        end
        @(posedge clk);
        if (t_reset) mp = 1'b0;
        else begin
            if (imem_rvalid && !force_rv) mp = 1'b0;
            else if (mp && mc > 0) mc--;
            if (s_req && t_ready) begin
                if (rand_lat) lat = $urandom_range(1, 3);
                mp = 1'b1; ma = s_addr; mc = lat - 1;
            end
        end
        force_rv = 1'b0;
    endtask

    task automatic do_reset();
        t_reset = 1'b1; t_redir = 1'b0;
        repeat (2) step();
        t_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // streaming with single-cycle memory
        do_reset();
        lat = 1; t_ready = 1'b1; t_oready = 1'b1; popped.delete();
        step();
        chk("first_req", s_req, 1'b1);
        chk("first_addr", s_addr, 32'h0);
        repeat (11) step();
        chk("stream_pc0", popped.size() > 3 ? popped[0] : 32'hFFFF_FFFF, 32'h0);
        chk("stream_pc1", popped.size() > 3 ? popped[1] : 32'hFFFF_FFFF, 32'h4);
        chk("stream_pc3", popped.size() > 3 ? popped[3] : 32'hFFFF_FFFF, 32'hC);
        begin
            int n;
            n = popped.size();
            repeat (6) step();
            chk("stream_rate", popped.size() - n, 6);
        end
        // decode stalled: fill, stray response in FETCH, then drain
        do_reset();
        t_oready = 1'b0; popped.delete();
        repeat (10) step();
        chk("full_req_low", s_req, 1'b0);
        chk("full_head_pc", s_pc, 32'h0);
        chk("full_count", m_q.size(), DEPTH);
        force_rv = 1'b1; force_data = 32'hDEAD_BEEF;
        step();
        t_oready = 1'b1;
        repeat (8) step();
        chk("drain_pc0", popped.size() > 4 ? popped[0] : 32'hFFFF_FFFF, 32'h0);
        chk("drain_pc2", popped.size() > 4 ? popped[2] : 32'hFFFF_FFFF, 32'h8);
        chk("drain_pc3", popped.size() > 4 ? popped[3] : 32'hFFFF_FFFF, 32'hC);
        chk("drain_pc4", popped.size() > 4 ? popped[4] : 32'hFFFF_FFFF, 32'h10);
        // memory not ready: address held
        do_reset();
        t_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_req", s_req, 1'b1);
            chk("stall_addr", s_addr, 32'h0);
        end
        t_ready = 1'b1;
        step();
        chk("stall_accept_addr", s_addr, 32'h0);
        step();
        chk("next_addr", s_addr, 32'h4);
        // redirect with an outstanding request on a 3-cycle memory
        do_reset();
        lat = 3; t_oready = 1'b0; popped.delete();
        for (int i = 0; i < 40 && !(s_req && s_addr == 32'h8); i++) step();
        chk("reach_req8", (s_req && s_addr == 32'h8), 1'b1);
        t_redir = 1'b1; t_rpc = 32'h0000_0103;
        step();
        t_redir = 1'b0;
        step();
        chk("redir_ov", s_ov, 1'b0);
        t_oready = 1'b1;
        for (int i = 0; i < 40 && popped.size() == 0; i++) step();
        chk("redir_first_pc", popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF, 32'h100);
        // redirect coinciding with pop and rvalid
        do_reset();
        lat = 1; t_oready = 1'b1;
        repeat (6) step();
        t_redir = 1'b1; t_rpc = 32'h200; popped.delete();
        step();
        t_redir = 1'b0;
        chk("coinc_rvalid", s_rv, 1'b1);
        chk("coinc_ov", s_ov, 1'b1);
        step();
        chk("coinc_empty", s_ov, 1'b0);
        chk("coinc_noreq", s_req, 1'b0);
        force_rv = 1'b1; force_data = 32'hBAD0_0000;
        step();
        for (int i = 0; i < 20 && popped.size() == 0; i++) step();
        chk("coinc_first_pc", popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF, 32'h200);
`ifdef FETCH_PERF_EN
        // perf counters: 5 pops then flush of 2 buffered + 1 outstanding
        do_reset();
        lat = 1; t_oready = 1'b1; popped.delete();
        for (int i = 0; i < 40 && popped.size() < 5; i++) step();
        t_oready = 1'b0; lat = 3;
        for (int i = 0; i < 40 && !(m_q.size() == 2 && m_infl && !(mp && mc == 0)); i++) step();
        t_redir = 1'b1; t_rpc = 32'h40;
        step();
        t_redir = 1'b0;
        for (int i = 0; i < 10 && m_infl; i++) step();
        step();
        chk("perf_fetched_lit", s_pf, 32'd5);
        chk("perf_flushed_lit", s_pfl, 32'd3);
`endif
        // randomized traffic
        do_reset();
        rand_lat = 1'b1;
        repeat (1500) begin
            t_reset  = $urandom_range(0, 199) == 0;
            t_redir  = !t_reset && $urandom_range(0, 19) == 0 && !(mp && mc == 0);
            t_rpc    = $urandom;
            t_ready  = $urandom_range(0, 9) < 7;
            t_oready = $urandom_range(0, 9) < 6;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
